// File: rtl/periph_bus_pkg.sv
// Shared types, size encodings and helpers for the peripheral bus arbiter.
package periph_bus_pkg;

  localparam int unsigned ACCESS_CYCLES_DEF = 2;
  localparam int unsigned LOCK_MAX          = 4;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned LOCK_W            = 3;

  typedef enum logic [1:0] {
    SZ_8  = 2'b00,
    SZ_16 = 2'b01,
    SZ_32 = 2'b10,
    SZ_64 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      SZ_8:    m = 3'b000;
      SZ_16:   m = 3'b001;
      SZ_32:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Requester handshakes and peripheral bus outputs of the arbiter (data bus is a separate inout).
interface periph_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) ();

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              we0;
  logic              we1;
  logic [1:0]        size0;
  logic [1:0]        size1;
  logic              lock1;

  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] address;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, size0, size1, lock1,
    output done0, done1, err0, err1, rdata, grant, address, mem_read, mem_write, size
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, size0, size1, lock1,
    input  done0, done1, err0, err1, rdata, grant, address, mem_read, mem_write, size
  );

endinterface

// File: rtl/periph_rr_pick.sv
// Two-way round-robin selector; lock forces requester 1 while it is requesting.
module periph_rr_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_ptr,
  input  logic       i_lock,
  output logic [1:0] o_pick_c
);

  always_comb begin
    o_pick_c = 2'b00;
    if (i_req1 && (i_lock || !i_req0 || i_ptr)) begin
      o_pick_c = 2'b10;
    end else if (i_req0) begin
      o_pick_c = 2'b01;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// CPU/DMA arbiter and fixed-window sequencer for the shared peripheral bus.
// Optional DMA burst lock enabled by defining PERIPH_ARB_DMA_LOCK_EN.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 64
) (
  input  logic              clock,
  input  logic              reset,
  periph_bus_arbiter_if.slave bus,
  inout  wire  [DATA_W-1:0] data
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_owner;
  logic              w_owner_nxt;
  logic              r_ptr;
  logic              w_ptr_nxt;
  logic [1:0]        r_grant;
  logic [1:0]        w_grant_nxt;
  logic              r_done0;
  logic              w_done0_nxt;
  logic              r_done1;
  logic              w_done1_nxt;
  logic              r_err0;
  logic              w_err0_nxt;
  logic              r_err1;
  logic              w_err1_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] w_address_nxt;
  logic [1:0]        r_size;
  logic [1:0]        w_size_nxt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              r_mem_read;
  logic              w_mem_read_nxt;
  logic              r_mem_write;
  logic              w_mem_write_nxt;
  logic              w_lock_active;

`ifdef PERIPH_ARB_DMA_LOCK_EN
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_lock_cnt_nxt;
  assign w_lock_active = (r_lock_cnt != '0);
`else
  assign w_lock_active = 1'b0;
`endif

  logic [1:0]        w_pick;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [1:0]        w_sel_size;
  logic              w_sel_we;
  logic              w_misaligned;

  periph_rr_pick u_pick (
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .i_ptr    (r_ptr),
    .i_lock   (w_lock_active),
    .o_pick_c (w_pick)
  );

  assign w_sel_addr   = w_pick[1] ? bus.addr1  : bus.addr0;
  assign w_sel_wdata  = w_pick[1] ? bus.wdata1 : bus.wdata0;
  assign w_sel_size   = w_pick[1] ? bus.size1  : bus.size0;
  assign w_sel_we     = w_pick[1] ? bus.we1    : bus.we0;
  assign w_misaligned = |(w_sel_addr[2:0] & align_mask(w_sel_size));

  // Data bus is driven only during the write window, released otherwise.
  assign data = r_mem_write ? r_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_ptr       <= 1'b0;
      r_grant     <= 2'b00;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata     <= '0;
      r_address   <= '0;
      r_size      <= 2'b00;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
`ifdef PERIPH_ARB_DMA_LOCK_EN
      r_lock_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_done0     <= w_done0_nxt;
      r_done1     <= w_done1_nxt;
      r_err0      <= w_err0_nxt;
      r_err1      <= w_err1_nxt;
      r_rdata     <= w_rdata_nxt;
      r_address   <= w_address_nxt;
      r_size      <= w_size_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
`ifdef PERIPH_ARB_DMA_LOCK_EN
      r_lock_cnt  <= w_lock_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_done0_nxt     = 1'b0;
    w_done1_nxt     = 1'b0;
    w_err0_nxt      = 1'b0;
    w_err1_nxt      = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_address_nxt   = r_address;
    w_size_nxt      = r_size;
    w_wdata_nxt     = r_wdata;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
`ifdef PERIPH_ARB_DMA_LOCK_EN
    w_lock_cnt_nxt  = r_lock_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_pick != 2'b00) begin
          w_owner_nxt = w_pick[1];
          w_grant_nxt = w_pick;
          if (w_misaligned) begin
            // Misaligned accesses complete with an error and never strobe the bus.
            w_state_nxt = ST_DONE;
            w_done0_nxt = !w_pick[1];
            w_done1_nxt = w_pick[1];
            w_err0_nxt  = !w_pick[1];
            w_err1_nxt  = w_pick[1];
          end else begin
            w_state_nxt     = ST_ACCESS;
            w_cnt_nxt       = CNT_W'(ACCESS_CYCLES - 1);
            w_address_nxt   = w_sel_addr;
            w_size_nxt      = w_sel_size;
            w_wdata_nxt     = w_sel_wdata;
            w_mem_read_nxt  = !w_sel_we;
            w_mem_write_nxt = w_sel_we;
          end
        end
      end

      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt     = ST_DONE;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_done0_nxt     = !r_owner;
          w_done1_nxt     = r_owner;
          if (r_mem_read) begin
            w_rdata_nxt = data;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
`ifdef PERIPH_ARB_DMA_LOCK_EN
        // A locked DMA keeps the pointer for up to LOCK_MAX repeats, then yields to the CPU.
        w_lock_cnt_nxt = '0;
        if (r_owner && bus.lock1 && (r_lock_cnt < LOCK_W'(LOCK_MAX))) begin
          w_ptr_nxt      = 1'b1;
          w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
        end else begin
          w_ptr_nxt = !r_owner;
        end
`else
        w_ptr_nxt = !r_owner;
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.rdata     = r_rdata;
  assign bus.grant     = r_grant;
  assign bus.address   = r_address;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.size      = r_size;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed self-checking bench for periph_bus_arbiter (default ACCESS_CYCLES=2).
module tb_periph_bus_arbiter;

  localparam logic [63:0] IDLE_PAT = 64'h5A5A_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] periph_val;
  wire  [63:0] data;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  periph_bus_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  periph_bus_arbiter u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .data  (data)
  );

  // Peripheral side: drives read data / an idle pattern whenever the arbiter is not writing.
  assign data = bus.mem_write ? 64'bz : periph_val;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One aligned read with both requesters contending; req seen in IDLE before the call.
  task automatic run_txn(input int owner, input string tag);
    tick();
    check({tag, "_grant"}, 64'(bus.grant), (owner == 1) ? 64'd2 : 64'd1);
    check({tag, "_rd_strobe"}, 64'(bus.mem_read), 64'd1);
    tick();
    tick();
    check({tag, "_done0"}, 64'(bus.done0), (owner == 0) ? 64'd1 : 64'd0);
    check({tag, "_done1"}, 64'(bus.done1), (owner == 1) ? 64'd1 : 64'd0);
    tick();
    check({tag, "_idle_grant"}, 64'(bus.grant), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    periph_val = IDLE_PAT;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.size0 = 2'b00; bus.size1 = 2'b00;
    tick(); tick(); tick();

    check("rst_grant",     64'(bus.grant),     64'd0);
    check("rst_done0",     64'(bus.done0),     64'd0);
    check("rst_done1",     64'(bus.done1),     64'd0);
    check("rst_err0",      64'(bus.err0),      64'd0);
    check("rst_rdata",     bus.rdata,          64'd0);
    check("rst_address",   64'(bus.address),   64'd0);
    check("rst_mem_read",  64'(bus.mem_read),  64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_size",      64'(bus.size),      64'd0);
    check("rst_data_rel",  data,               IDLE_PAT);
    rst = 1'b0;

    // CPU 64-bit read at 0x18
    periph_val = 64'h0000_0000_0000_A5A5;
    bus.req0 = 1'b1; bus.addr0 = 32'h18; bus.size0 = 2'b11; bus.we0 = 1'b0;
    tick();
    check("rd_c1_mem_read", 64'(bus.mem_read),  64'd1);
    check("rd_c1_mem_wr",   64'(bus.mem_write), 64'd0);
    check("rd_c1_grant",    64'(bus.grant),     64'd1);
    check("rd_c1_address",  64'(bus.address),   64'h18);
    check("rd_c1_size",     64'(bus.size),      64'd3);
    bus.addr0 = 32'hFF;
    tick();
    check("rd_c2_mem_read", 64'(bus.mem_read),  64'd1);
    check("rd_c2_addr_hold",64'(bus.address),   64'h18);
    tick();
    check("rd_c3_done0",    64'(bus.done0),     64'd1);
    check("rd_c3_err0",     64'(bus.err0),      64'd0);
    check("rd_c3_rdata",    bus.rdata,          64'h0000_0000_0000_A5A5);
    check("rd_c3_mem_read", 64'(bus.mem_read),  64'd0);
    check("rd_c3_grant",    64'(bus.grant),     64'd1);
    bus.req0 = 1'b0;
    periph_val = IDLE_PAT;
    tick();
    check("rd_c4_done0",    64'(bus.done0),     64'd0);
    check("rd_c4_grant",    64'(bus.grant),     64'd0);
    check("rd_c4_rdata",    bus.rdata,          64'h0000_0000_0000_A5A5);

    // DMA 16-bit write at 0x10
    bus.req1 = 1'b1; bus.addr1 = 32'h10; bus.wdata1 = 64'h00FF; bus.size1 = 2'b01; bus.we1 = 1'b1;
    check("wr_c0_data_rel", data, IDLE_PAT);
    tick();
    check("wr_c1_mem_write", 64'(bus.mem_write), 64'd1);
    check("wr_c1_mem_read",  64'(bus.mem_read),  64'd0);
    check("wr_c1_data",      data,               64'h00FF);
    check("wr_c1_grant",     64'(bus.grant),     64'd2);
    check("wr_c1_size",      64'(bus.size),      64'd1);
    tick();
    check("wr_c2_mem_write", 64'(bus.mem_write), 64'd1);
    check("wr_c2_data",      data,               64'h00FF);
    tick();
    check("wr_c3_done1",     64'(bus.done1),     64'd1);
    check("wr_c3_err1",      64'(bus.err1),      64'd0);
    check("wr_c3_mem_write", 64'(bus.mem_write), 64'd0);
    check("wr_c3_data_rel",  data,               IDLE_PAT);
    check("wr_c3_rdata_keep",bus.rdata,          64'h0000_0000_0000_A5A5);
    bus.req1 = 1'b0;
    tick();
    check("wr_c4_done1",     64'(bus.done1),     64'd0);

    // Misaligned CPU 32-bit access at 0x02
    bus.req0 = 1'b1; bus.addr0 = 32'h02; bus.size0 = 2'b10; bus.we0 = 1'b0;
    tick();
    check("mis_c1_done0",     64'(bus.done0),     64'd1);
    check("mis_c1_err0",      64'(bus.err0),      64'd1);
    check("mis_c1_mem_read",  64'(bus.mem_read),  64'd0);
    check("mis_c1_mem_write", 64'(bus.mem_write), 64'd0);
    bus.req0 = 1'b0;
    tick();
    check("mis_c2_done0",     64'(bus.done0),     64'd0);
    check("mis_c2_err0",      64'(bus.err0),      64'd0);
    check("mis_c2_mem_read",  64'(bus.mem_read),  64'd0);

    // Both requesters held: pointer favours DMA after the CPU was served last
    bus.addr0 = 32'h100; bus.size0 = 2'b11; bus.we0 = 1'b0;
    bus.addr1 = 32'h200; bus.size1 = 2'b11; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    run_txn(1, "rr0");
    run_txn(0, "rr1");
    run_txn(1, "rr2");
    run_txn(0, "rr3");
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Reset in the second write cycle aborts without done
    bus.req0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 64'h1234; bus.size0 = 2'b11; bus.we0 = 1'b1;
    tick();
    check("ab_c1_mem_write", 64'(bus.mem_write), 64'd1);
    tick();
    check("ab_c2_mem_write", 64'(bus.mem_write), 64'd1);
    rst = 1'b1;
    tick();
    check("ab_rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("ab_rst_data_rel",  data,               IDLE_PAT);
    check("ab_rst_grant",     64'(bus.grant),     64'd0);
    check("ab_rst_done0",     64'(bus.done0),     64'd0);
    rst = 1'b0;
    tick();
    check("ab_retry_mem_write", 64'(bus.mem_write), 64'd1);
    check("ab_retry_data",      data,               64'h1234);
    check("ab_retry_grant",     64'(bus.grant),     64'd1);
    tick();
    check("ab_retry_c2_done0",  64'(bus.done0),     64'd0);
    tick();
    check("ab_retry_done0",     64'(bus.done0),     64'd1);
    check("ab_retry_err0",      64'(bus.err0),      64'd0);
    bus.req0 = 1'b0;
    tick();

    // DMA lock: pointer is at DMA after the CPU retry
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.size0 = 2'b11; bus.size1 = 2'b11;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock1 = 1'b1;
`ifdef PERIPH_ARB_DMA_LOCK_EN
    run_txn(1, "lk0");
    run_txn(1, "lk1");
    run_txn(1, "lk2");
    run_txn(1, "lk3");
    run_txn(1, "lk4");
    run_txn(0, "lk5");
`else
    run_txn(1, "lk0");
    run_txn(0, "lk1");
    run_txn(1, "lk2");
    run_txn(0, "lk3");
    run_txn(1, "lk4");
    run_txn(0, "lk5");
`endif
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    tick();
    check("end_grant", 64'(bus.grant), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
